// File: rtl/adc083000_dcm_ctrl.sv
// adc083000_dcm_ctrl
// Sequences the ADC board clock DCM: either a reset pulse followed by a wait
// for lock, or a burst of dynamic phase-shift steps. Only one PSEN is ever
// outstanding. The controller tracks a signed net phase offset and refuses
// any step that would push it past +/-PS_LIMIT.
//
// Ports:
//   clk, reset        controller clock (also DCM PSCLK), sync active-high reset
//   cmd_valid/ready   command handshake; ready is high only in IDLE
//   cmd_op            0 = phase step burst, 1 = DCM reset
//   cmd_dir           1 = increment, 0 = decrement (steps only)
//   cmd_count         number of steps in the burst (0 is legal)
//   dcm_psen          one-cycle phase-shift enable
//   dcm_psincdec      latched direction, validated by dcm_psen
//   dcm_psdone        step completion from the DCM (clk domain)
//   dcm_rst           DCM reset, RST_CYCLES wide
//   dcm_locked        DCM lock, asynchronous, double-flopped here
//   phase_offset      signed net step count since the last DCM reset
//   busy, done        not-idle flag, one-cycle completion pulse
//   err_limit/err_timeout/err_unlocked  sticky until the next accepted command
module adc083000_dcm_ctrl #(
  parameter int PS_LIMIT   = 255,   // must be <= 511
  parameter int RST_CYCLES = 4,     // must be >= 3
  parameter int TIMEOUT    = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic              cmd_dir,
  input  logic [7:0]        cmd_count,
  output logic              dcm_psen,
  output logic              dcm_psincdec,
  input  logic              dcm_psdone,
  output logic              dcm_rst,
  input  logic              dcm_locked,
  output logic signed [9:0] phase_offset,
  output logic              busy,
  output logic              done,
  output logic              err_limit,
  output logic              err_timeout,
  output logic              err_unlocked
);

  typedef enum logic [2:0] {
    IDLE,
    RST_ASSERT,
    LOCK_WAIT,
    PS_CHECK,
    PS_ISSUE,
    PS_WAIT,
    FINISH
  } state_t;

  // One counter serves both the reset pulse width and the timeouts.
  localparam int CNT_MAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

  localparam logic signed [9:0] LIM_POS = 10'(PS_LIMIT);
  localparam logic signed [9:0] LIM_NEG = -LIM_POS;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [7:0]        remain_reg;
  logic              dir_reg;
  logic [1:0]        lock_sync_reg;
  logic signed [9:0] offset_reg;
  logic              psen_reg;
  logic              rst_reg;
  logic              done_reg;
  logic              ready_reg;
  logic              busy_reg;
  logic              err_limit_reg;
  logic              err_timeout_reg;
  logic              err_unlocked_reg;

  logic lock_ok;
  logic at_limit;

  assign lock_ok = lock_sync_reg[1];

  // Checked before the step is issued, so the offset can never leave
  // [-PS_LIMIT, PS_LIMIT] and the 10-bit register cannot wrap.
  assign at_limit = dir_reg ? (offset_reg >= LIM_POS) : (offset_reg <= LIM_NEG);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      remain_reg       <= '0;
      dir_reg          <= 1'b0;
      lock_sync_reg    <= '0;
      offset_reg       <= '0;
      psen_reg         <= 1'b0;
      rst_reg          <= 1'b0;
      done_reg         <= 1'b0;
      ready_reg        <= 1'b1;
      busy_reg         <= 1'b0;
      err_limit_reg    <= 1'b0;
      err_timeout_reg  <= 1'b0;
      err_unlocked_reg <= 1'b0;
    end else begin
      lock_sync_reg <= {lock_sync_reg[0], dcm_locked};
      // Pulse outputs default low; the branches below raise them for one cycle.
      psen_reg <= 1'b0;
      done_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            ready_reg        <= 1'b0;
            busy_reg         <= 1'b1;
            err_limit_reg    <= 1'b0;
            err_timeout_reg  <= 1'b0;
            err_unlocked_reg <= 1'b0;
            dir_reg          <= cmd_dir;
            remain_reg       <= cmd_count;
            cnt_reg          <= '0;
            if (cmd_op) begin
              rst_reg    <= 1'b1;
              offset_reg <= '0;
              state_reg  <= RST_ASSERT;
            end else begin
              state_reg  <= PS_CHECK;
            end
          end
        end

        RST_ASSERT: begin
          if (cnt_reg == RST_LAST) begin
            rst_reg   <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= LOCK_WAIT;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        LOCK_WAIT: begin
          if (lock_ok) begin
            done_reg  <= 1'b1;
            state_reg <= FINISH;
          end else if (cnt_reg == TO_LAST) begin
            err_timeout_reg <= 1'b1;
            done_reg        <= 1'b1;
            state_reg       <= FINISH;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        PS_CHECK: begin
          if (remain_reg == 8'd0) begin
            done_reg  <= 1'b1;
            state_reg <= FINISH;
          end else if (!lock_ok) begin
            err_unlocked_reg <= 1'b1;
            done_reg         <= 1'b1;
            state_reg        <= FINISH;
          end else if (at_limit) begin
            err_limit_reg <= 1'b1;
            done_reg      <= 1'b1;
            state_reg     <= FINISH;
          end else begin
            // PSEN is registered, so it is high exactly while in PS_ISSUE.
            psen_reg  <= 1'b1;
            state_reg <= PS_ISSUE;
          end
        end

        PS_ISSUE: begin
          cnt_reg   <= '0;
          state_reg <= PS_WAIT;
        end

        PS_WAIT: begin
          if (dcm_psdone) begin
            offset_reg <= dir_reg ? offset_reg + 10'sd1 : offset_reg - 10'sd1;
            remain_reg <= remain_reg - 8'd1;
            state_reg  <= PS_CHECK;
          end else if (cnt_reg == TO_LAST) begin
            err_timeout_reg <= 1'b1;
            done_reg        <= 1'b1;
            state_reg       <= FINISH;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        FINISH: begin
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
          rst_reg   <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready    = ready_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign dcm_psen     = psen_reg;
  assign dcm_psincdec = dir_reg;
  assign dcm_rst      = rst_reg;
  assign phase_offset = offset_reg;
  assign err_limit    = err_limit_reg;
  assign err_timeout  = err_timeout_reg;
  assign err_unlocked = err_unlocked_reg;

endmodule

// File: tb/tb_adc083000_dcm_ctrl.sv
// Testbench for adc083000_dcm_ctrl: a directed table of commands, two reset
// abort sequences, then randomized commands checked against a transaction
// level model. A small DCM model answers PSEN with PSDONE and drives lock.
module tb_adc083000_dcm_ctrl;

  localparam int PS_LIMIT   = 6;
  localparam int RST_CYCLES = 4;
  localparam int TIMEOUT    = 16;
  localparam int LOCK_DLY   = 8;    // auto-lock rises this many cycles after dcm_rst falls
  localparam int MAX_WAIT   = 300;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic              cmd_dir;
  logic [7:0]        cmd_count;
  logic              dcm_psen;
  logic              dcm_psincdec;
  logic              dcm_psdone;
  logic              dcm_rst;
  logic              dcm_locked;
  logic signed [9:0] phase_offset;
  logic              busy;
  logic              done;
  logic              err_limit;
  logic              err_timeout;
  logic              err_unlocked;

  always #5 clk = ~clk;

  adc083000_dcm_ctrl #(
    .PS_LIMIT  (PS_LIMIT),
    .RST_CYCLES(RST_CYCLES),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_dir     (cmd_dir),
    .cmd_count   (cmd_count),
    .dcm_psen    (dcm_psen),
    .dcm_psincdec(dcm_psincdec),
    .dcm_psdone  (dcm_psdone),
    .dcm_rst     (dcm_rst),
    .dcm_locked  (dcm_locked),
    .phase_offset(phase_offset),
    .busy        (busy),
    .done        (done),
    .err_limit   (err_limit),
    .err_timeout (err_timeout),
    .err_unlocked(err_unlocked)
  );

  typedef struct {
    bit op;
    bit dir;
    int cnt;
    bit lock;
    bit auto_lock;
    bit never;
    int lat;
    int e_psen;
    int e_off;
    int e_done;
    bit e_lim;
    bit e_to;
    bit e_unl;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // DCM model controls
  int psdone_lat   = 0;
  bit psdone_never = 1'b0;
  bit lock_auto    = 1'b0;
  bit lock_level   = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // PSDONE arrives in the cycle psdone_lat+1 after the PSEN cycle.
  initial begin
    dcm_psdone = 1'b0;
    forever begin
      @(negedge clk);
      if (dcm_psen && !psdone_never) begin
        @(posedge clk);
        repeat (psdone_lat) @(posedge clk);
        #1 dcm_psdone = 1'b1;
        @(posedge clk);
        #1 dcm_psdone = 1'b0;
      end
    end
  end

  // Lock: either held at lock_level, or dropped by dcm_rst and restored
  // LOCK_DLY cycles after dcm_rst falls.
  initial begin
    int since;
    since = 0;
    dcm_locked = 1'b1;
    forever begin
      @(negedge clk);
      if (!lock_auto) begin
        dcm_locked = lock_level;
        since = 0;
      end else if (dcm_rst) begin
        dcm_locked = 1'b0;
        since = 0;
      end else if (!dcm_locked) begin
        since++;
        if (since >= LOCK_DLY) dcm_locked = 1'b1;
      end
    end
  end

  function automatic vec_t mk(input bit op, input bit dir, input int cnt, input bit lock,
                              input bit auto_lock, input bit never, input int lat,
                              input int e_psen, input int e_off, input int e_done,
                              input bit e_lim, input bit e_to, input bit e_unl);
    vec_t v;
    v.op = op; v.dir = dir; v.cnt = cnt; v.lock = lock; v.auto_lock = auto_lock;
    v.never = never; v.lat = lat; v.e_psen = e_psen; v.e_off = e_off;
    v.e_done = e_done; v.e_lim = e_lim; v.e_to = e_to; v.e_unl = e_unl;
    return v;
  endfunction

  // Whole-command outcome from the rules: each step costs (latency + 3) cycles,
  // steps stop at the limit, a silent DCM costs one PSEN plus TIMEOUT cycles.
  function automatic vec_t model(input bit op, input bit dir, input int cnt, input bit lock,
                                 input int lat, input bit never, input int off);
    vec_t v;
    int avail;
    int n;
    v = mk(op, dir, cnt, lock, 1'b0, never, lat, 0, off, 2, 1'b0, 1'b0, 1'b0);
    if (op) begin
      v.e_off = 0;
      if (lock) v.e_done = RST_CYCLES + 2;
      else begin
        v.e_to = 1'b1;
        v.e_done = RST_CYCLES + TIMEOUT + 1;
      end
    end else if (cnt == 0) begin
      v.e_done = 2;
    end else if (!lock) begin
      v.e_unl = 1'b1;
    end else begin
      avail = dir ? PS_LIMIT - off : PS_LIMIT + off;
      if (avail == 0) begin
        v.e_lim = 1'b1;
      end else if (never) begin
        v.e_psen = 1;
        v.e_to = 1'b1;
        v.e_done = 3 + TIMEOUT;
      end else begin
        n = (cnt < avail) ? cnt : avail;
        v.e_lim = (cnt > avail);
        v.e_psen = n;
        v.e_off = dir ? off + n : off - n;
        v.e_done = 2 + n * (lat + 3);
      end
    end
    return v;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, ".cmd_ready"}, cmd_ready, 1);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".psen"}, dcm_psen, 0);
    check({tag, ".psincdec"}, dcm_psincdec, 0);
    check({tag, ".dcm_rst"}, dcm_rst, 0);
    check({tag, ".offset"}, int'(phase_offset), 0);
    check({tag, ".err_limit"}, err_limit, 0);
    check({tag, ".err_timeout"}, err_timeout, 0);
    check({tag, ".err_unlocked"}, err_unlocked, 0);
  endtask

  // Presents a command in cycle 0; returns 1 ns into cycle 1.
  task automatic issue(input bit op, input bit dir, input int cnt);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_dir = dir; cmd_count = 8'(cnt);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic apply(input vec_t v, input string tag);
    int done_cyc, psen_n, done_n, rst_n, rst_first, last_psen;
    int gap_min, gap_max, b2b, bad_dir, lim_d, to_d, unl_d;
    done_cyc = -1; psen_n = 0; done_n = 0; rst_n = 0; rst_first = -1; last_psen = -10;
    gap_min = 1000; gap_max = -1; b2b = 0; bad_dir = 0; lim_d = -1; to_d = -1; unl_d = -1;
    lock_auto = v.auto_lock; lock_level = v.lock;
    psdone_lat = v.lat; psdone_never = v.never;
    repeat (4) @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_op = v.op; cmd_dir = v.dir; cmd_count = 8'(v.cnt);
    @(negedge clk);
    check({tag, ".ready_idle"}, cmd_ready, 1);
    @(posedge clk);
    #1;
    // Scribble on the command fields while busy; they must be ignored.
    cmd_valid = 1'b0;
    cmd_op = 1'($urandom); cmd_dir = 1'($urandom); cmd_count = 8'($urandom);
    for (int cyc = 1; cyc <= MAX_WAIT; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        check({tag, ".ready_low"}, cmd_ready, 0);
        check({tag, ".busy_high"}, busy, 1);
      end
      if (dcm_psen) begin
        psen_n++;
        if (last_psen == cyc - 1) b2b++;
        if (last_psen > 0) begin
          if (cyc - last_psen < gap_min) gap_min = cyc - last_psen;
          if (cyc - last_psen > gap_max) gap_max = cyc - last_psen;
        end
        if (dcm_psincdec != v.dir) bad_dir++;
        last_psen = cyc;
      end
      if (dcm_rst) begin
        rst_n++;
        if (rst_first < 0) rst_first = cyc;
      end
      if (done) begin
        done_n++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          lim_d = err_limit; to_d = err_timeout; unl_d = err_unlocked;
        end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        check({tag, ".ready_after"}, cmd_ready, 1);
        check({tag, ".busy_after"}, busy, 0);
        break;
      end
      @(posedge clk);
    end
    if (done_cyc < 0) begin
      check({tag, ".done_seen"}, 0, 1);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
    end else begin
      check({tag, ".done_cycle"}, done_cyc, v.e_done);
      check({tag, ".done_count"}, done_n, 1);
      check({tag, ".psen_count"}, psen_n, v.e_psen);
      check({tag, ".offset"}, int'(phase_offset), v.e_off);
      check({tag, ".err_limit"}, lim_d, int'(v.e_lim));
      check({tag, ".err_timeout"}, to_d, int'(v.e_to));
      check({tag, ".err_unlocked"}, unl_d, int'(v.e_unl));
      check({tag, ".psen_b2b"}, b2b, 0);
      check({tag, ".psincdec"}, bad_dir, 0);
      if (v.e_psen >= 2) begin
        check({tag, ".gap_min"}, gap_min, v.lat + 3);
        check({tag, ".gap_max"}, gap_max, v.lat + 3);
      end
      check({tag, ".rst_width"}, rst_n, v.op ? RST_CYCLES : 0);
      if (v.op) check({tag, ".rst_first"}, rst_first, 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[11];
    vec_t v;
    int model_off;
    int done_n, psen_n;

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_dir = 1'b0; cmd_count = 8'd0;

    //              op dir cnt lk aut nev lat psen off  done lim to unl
    tbl[0]  = mk(1, 0, 0, 1, 0, 0, 0,  0,  0,  6, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 1, 1, 0, 0,  0,  0, RST_CYCLES + LOCK_DLY + 3, 0, 0, 0);
    tbl[2]  = mk(0, 1, 5, 1, 0, 0, 10, 5,  5, 67, 0, 0, 0);
    tbl[3]  = mk(0, 1, 3, 1, 0, 0, 2,  1,  6,  7, 1, 0, 0);
    tbl[4]  = mk(0, 0, 0, 1, 0, 0, 0,  0,  6,  2, 0, 0, 0);
    tbl[5]  = mk(0, 0, 4, 1, 0, 0, 0,  4,  2, 14, 0, 0, 0);
    tbl[6]  = mk(0, 0, 2, 0, 0, 0, 0,  0,  2,  2, 0, 0, 1);
    tbl[7]  = mk(0, 0, 1, 1, 0, 1, 0,  1,  2, 19, 0, 1, 0);
    tbl[8]  = mk(0, 0, 9, 1, 0, 0, 1,  8, -6, 34, 1, 0, 0);
    tbl[9]  = mk(0, 1, 1, 1, 0, 0, 3,  1, -5,  8, 0, 0, 0);
    tbl[10] = mk(1, 1, 0, 0, 0, 0, 0,  0,  0, 21, 0, 1, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("por");
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_vals("por_release");

    for (int i = 0; i < 11; i++) apply(tbl[i], $sformatf("row%0d", i));

    // Abort in PS_WAIT; the pending PSDONE then lands in IDLE and must be ignored.
    lock_auto = 1'b0; lock_level = 1'b1; psdone_lat = 10; psdone_never = 1'b0;
    repeat (4) @(posedge clk);
    issue(1'b0, 1'b1, 3);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("abort_ps");
    @(posedge clk);
    #1 reset = 1'b0;
    done_n = 0; psen_n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) done_n++;
      if (dcm_psen) psen_n++;
    end
    check("abort_ps.no_done", done_n, 0);
    check("abort_ps.no_psen", psen_n, 0);
    check("stray_psdone.offset", int'(phase_offset), 0);
    check("abort_ps.ready", cmd_ready, 1);

    // Abort in RST_ASSERT: dcm_rst must drop immediately.
    issue(1'b1, 1'b0, 0);
    @(negedge clk);
    check("abort_rst.rst_active", dcm_rst, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("abort_rst");
    @(posedge clk);
    #1 reset = 1'b0;
    done_n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done || dcm_rst) done_n++;
    end
    check("abort_rst.quiet", done_n, 0);

    // Randomized commands against the transaction model.
    model_off = 0;
    for (int i = 0; i < 40; i++) begin
      v = model(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                $urandom_range(0, 10), ($urandom_range(0, 7) != 0),
                $urandom_range(0, 6), ($urandom_range(0, 7) == 0), model_off);
      apply(v, $sformatf("rnd%0d", i));
      model_off = v.e_off;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adc083000_dcm_ctrl.md
# adc083000_dcm_ctrl

Sequencer for the ADC board clock DCM's dynamic phase shift and reset. It sits between a software/register front end and the DCM control ports of the adc083000 board PHY (`dcm_psen`, `dcm_psincdec`, `dcm_psdone`, `dcm_rst`, `adc_dcm_locked`). It accepts one command at a time: a DCM reset, or a burst of N phase steps. It issues one PSEN pulse per step, waits for PSDONE, and tracks a signed phase offset with limit and timeout protection.

## Interface
Parameters:
- `PS_LIMIT`, 255: maximum absolute phase offset in DCM steps. Must be ≤ 511.
- `RST_CYCLES`, 4: width of the `dcm_rst` pulse in `clk` cycles. Must be ≥ 3.
- `TIMEOUT`, 65535: maximum wait, in cycles, for PSDONE or for lock.

Ports:
- `clk` in 1: controller clock. It is the same clock that drives the DCM `PSCLK`.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_op` in 1: 0 = phase step burst, 1 = DCM reset.
- `cmd_dir` in 1: 1 = increment, 0 = decrement. Used only for steps.
- `cmd_count` in 8: number of steps. 0 is legal.
- `dcm_psen` out 1: one-cycle phase-shift enable to the DCM.
- `dcm_psincdec` out 1: direction to the DCM.
- `dcm_psdone` in 1: DCM step completion. Synchronous to `clk`.
- `dcm_rst` out 1: DCM reset.
- `dcm_locked` in 1: DCM lock. Asynchronous; resynchronised internally with 2 flops.
- `phase_offset` out 10: signed two's-complement net step count since the last DCM reset.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse when a command completes, successfully or not.
- `err_limit` out 1: sticky error flag.
- `err_timeout` out 1: sticky error flag.
- `err_unlocked` out 1: sticky error flag.

## Operation
- States: IDLE, RST_ASSERT, LOCK_WAIT, PS_CHECK, PS_ISSUE, PS_WAIT, FINISH.
- Accept: a command is accepted when `cmd_valid & cmd_ready`.
  - On accept, all three error flags clear.
  - `cmd_dir` and `cmd_count` are latched.
  - `cmd_op`=1 goes to RST_ASSERT. `cmd_op`=0 goes to PS_CHECK.
- RST_ASSERT:
  - `dcm_rst`=1 for exactly RST_CYCLES cycles.
  - `phase_offset` is set to 0 on entry.
  - Then go to LOCK_WAIT with the timeout counter cleared.
- LOCK_WAIT:
  - When the synced lock is high, go to FINISH.
  - When the counter reaches TIMEOUT, set `err_timeout` and go to FINISH.
- PS_CHECK, evaluated in this priority order:
  1. Remaining count is 0: go to FINISH.
  2. Synced lock is low: set `err_unlocked` and go to FINISH.
  3. The next step would make |`phase_offset`| > PS_LIMIT: set `err_limit` and go to FINISH. No PSEN is issued.
  4. Otherwise go to PS_ISSUE.
- PS_ISSUE:
  - `dcm_psen`=1 for one cycle, with `dcm_psincdec`=dir.
  - Clear the timeout counter and go to PS_WAIT.
- PS_WAIT, on `dcm_psdone`=1:
  - `phase_offset` += 1 for increment, −1 for decrement.
  - Remaining count −1.
  - Go to PS_CHECK.
- PS_WAIT timeout: after TIMEOUT cycles without PSDONE, set `err_timeout`, leave the offset unchanged, and go to FINISH.
- FINISH: `done`=1 for one cycle, then return to IDLE.
- `dcm_psincdec` holds the latched dir in every state (0 after reset). Only PSEN validates it.
- Lock loss during PS_WAIT is ignored. It is caught at the next PS_CHECK.
- A `dcm_psdone` that arrives outside PS_WAIT is ignored.
- Changes to `cmd_*` while busy are ignored.

## Timing
- Reset values:
  - State IDLE.
  - `cmd_ready`=1.
  - `busy`, `done`, `dcm_psen`, `dcm_psincdec`, `dcm_rst`, and all error flags = 0.
  - `phase_offset`=0.
- A reset asserted mid-operation aborts immediately to reset values. This includes deasserting `dcm_rst` mid-pulse. No `done` is produced.
- Step command latency:
  - Accept at cycle 0.
  - PS_CHECK at cycle 1.
  - `dcm_psen` high at cycle 2.
  - PSDONE sampled at cycle k ≥ 3.
  - The offset update is visible at cycle k+1.
  - The next PSEN is at k+2.
  - Steady rate: one step per (PSDONE latency + 3) cycles.
- Never more than one PSEN outstanding. PSEN is never asserted in two consecutive cycles.
- `count`=0: `done` at cycle 2, no PSEN.
- Reset command:
  - `dcm_rst` is high during cycles 1..RST_CYCLES.
  - LOCK_WAIT starts at RST_CYCLES+1.
  - The lock synchroniser adds 2 cycles before lock is seen.
- `cmd_ready` falls the cycle after accept. It rises the cycle after the `done` pulse.
- Arithmetic: `phase_offset` is 10-bit signed. The limit check compares ±PS_LIMIT before the update, so wrap-around cannot occur.

## Test plan
- Reset DCM:
  - Stimulus: `cmd_op`=1, RST_CYCLES=4, model lock rising 20 cycles after `dcm_rst` falls.
  - Required: `dcm_rst` high for exactly 4 cycles, `phase_offset`=0, one `done` pulse, no error flags.
- Increment burst:
  - Stimulus: count=5, dir=1, PSDONE model latency 10 cycles.
  - Required: exactly 5 one-cycle PSEN pulses with `dcm_psincdec`=1, `phase_offset`=5, `done` once, PSEN spacing 13 cycles.
- Limit:
  - Stimulus: PS_LIMIT=3, offset −2, command dir=0 count=4.
  - Required: 1 PSEN, `phase_offset`=−3, `err_limit`=1, `done`.
  - Then: a new command dir=1 count=1 clears `err_limit` and gives offset −2.
- Timeout:
  - Stimulus: TIMEOUT=16, PSDONE never asserted.
  - Required: 1 PSEN, `err_timeout`=1 after 16 wait cycles, offset unchanged.
  - Also: a reset command with lock held low gives `err_timeout` with no hang.
- Unlocked and zero count:
  - Stimulus: lock low, step count=3.
  - Required: no PSEN, `err_unlocked`=1.
  - Stimulus: count=0 with lock high.
  - Required: `done` at cycle 2, no PSEN, no error flags.
- Abort:
  - Stimulus: `reset` asserted during PS_WAIT and again during RST_ASSERT.
  - Required: all outputs at reset values next cycle, `cmd_ready`=1, no `done`.
  - Also: a stray PSDONE in IDLE leaves the offset unchanged.
